// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file.
// The write-to-read bypass is built when REGFILE_BYPASS_EN is defined.
package regfile_pkg;

   localparam int RF_DATA_W   = 64;
   localparam int RF_NUM_REGS = 32;
   localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);
   localparam int RF_ZERO_REG = 31;

   localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = RF_ADDR_W'(RF_ZERO_REG);

   function automatic logic is_zero_reg(input logic [RF_ADDR_W-1:0] addr);
      return addr == RF_ZERO_ADDR;
   endfunction

endpackage

// File: rtl/regfile_decoder.sv
// Write-enable decoder: one-hot select of the write address, gated by
// the write enable. The hardwired-zero register never gets a select.
module regfile_decoder
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic                 en,
   input  logic [RF_ADDR_W-1:0] addr,
   output logic [NUM_REGS-1:0]  sel
);

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (addr == RF_ADDR_W'(i))) begin
            sel[i] = 1'b1;
         end
      end
      sel[RF_ZERO_REG] = 1'b0;
   end

endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file; register 31 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int NUM_REGS = RF_NUM_REGS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RegWrite,
   input  logic [RF_ADDR_W-1:0] WriteRegister,
   input  logic [DATA_W-1:0]    WriteData,
   input  logic [RF_ADDR_W-1:0] ReadRegister1,
   input  logic [RF_ADDR_W-1:0] ReadRegister2,
   output logic [DATA_W-1:0]    ReadData1,
   output logic [DATA_W-1:0]    ReadData2
);

   localparam int NSTORE = NUM_REGS - 1;

   logic [NUM_REGS-1:0] wr_sel;
   logic [DATA_W-1:0]   regs [NSTORE];
   logic                unused_sel;

   regfile_decoder #(
      .NUM_REGS (NUM_REGS)
   ) u_dec (
      .en   (RegWrite),
      .addr (WriteRegister),
      .sel  (wr_sel)
   );

   // The zero register has no storage, so its select bit goes nowhere.
   assign unused_sel = wr_sel[NUM_REGS-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSTORE; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NSTORE; i++) begin
            if (wr_sel[i]) begin
               regs[i] <= WriteData;
            end
         end
      end
   end

   always_comb begin
      ReadData1 = '0;
      ReadData2 = '0;
      for (int i = 0; i < NSTORE; i++) begin
         if (ReadRegister1 == RF_ADDR_W'(i)) begin
            ReadData1 = regs[i];
         end
         if (ReadRegister2 == RF_ADDR_W'(i)) begin
            ReadData2 = regs[i];
         end
      end
`ifdef REGFILE_BYPASS_EN
      // Forwarding is held off in reset so reads stay zero.
      if (rst_n && RegWrite && !is_zero_reg(WriteRegister)) begin
         if (ReadRegister1 == WriteRegister) begin
            ReadData1 = WriteData;
         end
         if (ReadRegister2 == WriteRegister) begin
            ReadData2 = WriteData;
         end
      end
`endif
   end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: scoreboard of expected read data
// against a small reference model of the register contents.
module tb_regfile;

   logic        clk;
   logic        rst_n;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [63:0] ReadData1;
   logic [63:0] ReadData2;

   int checks;
   int failures;

   logic [63:0] model [32];
   logic [63:0] sb_q [$];
   logic [63:0] exp_v;

   localparam logic [63:0] PAT = 64'h0000010204080001;

   regfile dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [63:0] d);
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = a;
      WriteData     = d;
      @(posedge clk);
      if (a != 5'd31) model[a] = d;
      #1;
      RegWrite = 1'b0;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      RegWrite      = 1'b1;
      WriteRegister = 5'd3;
      WriteData     = 64'hDEAD_BEEF_0000_0003;
      model_clear();
      repeat (3) @(posedge clk);
      for (int i = 0; i < 32; i += 7) begin
         ReadRegister1 = 5'(i);
         ReadRegister2 = 5'(31 - i);
         sb_q.push_back(64'h0);
         sb_q.push_back(64'h0);
         #1;
         exp_v = sb_q.pop_front();
         checks++;
         if (ReadData1 !== exp_v) begin
            failures++;
            $display("FAIL reset_rd1[%0d] got=%h exp=%h", i, ReadData1, exp_v);
         end
         exp_v = sb_q.pop_front();
         checks++;
         if (ReadData2 !== exp_v) begin
            failures++;
            $display("FAIL reset_rd2[%0d] got=%h exp=%h", i, ReadData2, exp_v);
         end
      end
      @(negedge clk);
      RegWrite = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      ReadRegister1 = 5'd3;
      sb_q.push_back(model[3]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData1 !== exp_v) begin
         failures++;
         $display("FAIL reset_write_ignored got=%h exp=%h", ReadData1, exp_v);
      end
   endtask

   task automatic test_zero_reg();
      do_write(5'd31, 64'hA0);
      ReadRegister1 = 5'd31;
      ReadRegister2 = 5'd31;
      sb_q.push_back(64'h0);
      sb_q.push_back(64'h0);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData1 !== exp_v) begin
         failures++;
         $display("FAIL zero_reg_rd1 got=%h exp=%h", ReadData1, exp_v);
      end
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData2 !== exp_v) begin
         failures++;
         $display("FAIL zero_reg_rd2 got=%h exp=%h", ReadData2, exp_v);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 31; i++) begin
         do_write(5'(i), 64'(i) * PAT);
      end
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i - 1);
         ReadRegister2 = 5'(i);
         sb_q.push_back((i == 0) ? 64'h0 : 64'(i - 1) * PAT);
         sb_q.push_back((i == 31) ? 64'h0 : 64'(i) * PAT);
         #1;
         exp_v = sb_q.pop_front();
         checks++;
         if (ReadData1 !== exp_v) begin
            failures++;
            $display("FAIL fill_rd1[%0d] got=%h exp=%h", i, ReadData1, exp_v);
         end
         exp_v = sb_q.pop_front();
         checks++;
         if (ReadData2 !== exp_v) begin
            failures++;
            $display("FAIL fill_rd2[%0d] got=%h exp=%h", i, ReadData2, exp_v);
         end
      end
   endtask

   task automatic test_gating();
      @(negedge clk);
      RegWrite      = 1'b0;
      WriteRegister = 5'd5;
      WriteData     = 64'h505;
      repeat (4) @(posedge clk);
      #1;
      ReadRegister1 = 5'd5;
      sb_q.push_back(model[5]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData1 !== exp_v) begin
         failures++;
         $display("FAIL gating_reg5 got=%h exp=%h", ReadData1, exp_v);
      end
   endtask

   task automatic test_bypass();
      @(negedge clk);
      RegWrite      = 1'b1;
      WriteRegister = 5'd30;
      WriteData     = 64'd5;
      ReadRegister1 = 5'd30;
`ifdef REGFILE_BYPASS_EN
      sb_q.push_back(64'd5);
`else
      sb_q.push_back(model[30]);
`endif
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData1 !== exp_v) begin
         failures++;
         $display("FAIL bypass_before got=%h exp=%h", ReadData1, exp_v);
      end
      @(posedge clk);
      model[30] = 64'd5;
      sb_q.push_back(model[30]);
      #1;
      RegWrite = 1'b0;
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData1 !== exp_v) begin
         failures++;
         $display("FAIL bypass_after got=%h exp=%h", ReadData1, exp_v);
      end
   endtask

   task automatic test_async_reset();
      do_write(5'd30, 64'd5);
      @(negedge clk);
      ReadRegister1 = 5'd30;
      ReadRegister2 = 5'd12;
      sb_q.push_back(model[30]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData1 !== exp_v) begin
         failures++;
         $display("FAIL async_pre got=%h exp=%h", ReadData1, exp_v);
      end
      rst_n = 1'b0;
      model_clear();
      sb_q.push_back(model[30]);
      sb_q.push_back(model[12]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData1 !== exp_v) begin
         failures++;
         $display("FAIL async_rd1 got=%h exp=%h", ReadData1, exp_v);
      end
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData2 !== exp_v) begin
         failures++;
         $display("FAIL async_rd2 got=%h exp=%h", ReadData2, exp_v);
      end
      RegWrite      = 1'b1;
      WriteRegister = 5'd7;
      WriteData     = 64'h7777;
      @(posedge clk);
      @(negedge clk);
      RegWrite = 1'b0;
      rst_n    = 1'b1;
      ReadRegister1 = 5'd7;
      sb_q.push_back(model[7]);
      #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (ReadData1 !== exp_v) begin
         failures++;
         $display("FAIL async_write_abort got=%h exp=%h", ReadData1, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] d;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         d = {$urandom, $urandom};
         RegWrite      = 1'b1;
         WriteRegister = 5'(i * 4 + 1);
         WriteData     = d;
         @(posedge clk);
         if (WriteRegister != 5'd31) model[WriteRegister] = d;
         #1;
         ReadRegister1 = WriteRegister;
         ReadRegister2 = 5'(i * 4 + 29);
         sb_q.push_back(model[WriteRegister]);
         sb_q.push_back(model[5'(i * 4 + 29)]);
         #1;
         exp_v = sb_q.pop_front();
         checks++;
         if (ReadData1 !== exp_v) begin
            failures++;
            $display("FAIL b2b_rd1[%0d] got=%h exp=%h", i, ReadData1, exp_v);
         end
         exp_v = sb_q.pop_front();
         checks++;
         if (ReadData2 !== exp_v) begin
            failures++;
            $display("FAIL b2b_rd2[%0d] got=%h exp=%h", i, ReadData2, exp_v);
         end
         @(negedge clk);
      end
      RegWrite = 1'b0;
      for (int i = 0; i < 32; i++) begin
         ReadRegister1 = 5'(i);
         sb_q.push_back(model[i]);
         #1;
         exp_v = sb_q.pop_front();
         checks++;
         if (ReadData1 !== exp_v) begin
            failures++;
            $display("FAIL b2b_final[%0d] got=%h exp=%h", i, ReadData1, exp_v);
         end
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      RegWrite      = 1'b0;
      WriteRegister = '0;
      WriteData     = '0;
      ReadRegister1 = '0;
      ReadRegister2 = '0;
      test_reset();
      test_zero_reg();
      test_fill();
      test_gating();
      test_bypass();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
